// File: rtl/zld_xc.sv
// Zero run-length decoder: literals pass through, run tokens expand into L zero tokens.
// Registered output slot with valid/backpressure on both sides.
module zld_xc #(
    parameter int unsigned Wi = 3,
    parameter int unsigned Wo = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [Wi-1:0] i_d,
    input  logic          i_v,
    output logic          i_b,
    output logic [Wo-1:0] o_d,
    output logic          o_v,
    input  logic          o_b
);

    localparam int unsigned CW = Wi - 1;

    typedef enum logic {
        PASS = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          slot_free;
    logic          in_xfer;
    logic          is_run;
    logic [CW-1:0] payload;

    assign slot_free = !o_v || !o_b;
    assign i_b       = (state == RUN) ? 1'b1 : (o_v & o_b);
    assign in_xfer   = i_v && !i_b;
    assign is_run    = i_d[Wi-1];
    assign payload   = i_d[Wi-2:0];

    // In PASS an accepted token always lands in a free slot, since i_b covers the stalled case.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= PASS;
            cnt   <= '0;
            o_d   <= '0;
            o_v   <= 1'b0;
        end else begin
            case (state)
                PASS: begin
                    if (in_xfer) begin
                        o_v <= 1'b1;
                        if (is_run) begin
                            o_d <= '0;
                            cnt <= payload;
                            if (payload != '0) begin
                                state <= RUN;
                            end
                        end else begin
                            o_d <= i_d[Wo-1:0];
                        end
                    end else if (slot_free) begin
                        o_v <= 1'b0;
                    end
                end
                RUN: begin
                    if (slot_free) begin
                        o_d <= '0;
                        o_v <= 1'b1;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= PASS;
                        end
                    end
                end
                default: state <= PASS;
            endcase
        end
    end

endmodule
